aes_block_scheduler: RTL

//  Sequencing controller for the AES accelerator. Sits between the AHB-Lite slave register file and the single AES round core.
//  - Tracks the input block slots (AHB 0x40-0x7C) and output slots (0x80-0xBC).
//  - Triggers key expansion after a key write (0x10-0x1C).
//  - Issues buffered blocks to the core one at a time in the selected mode (0x04 encrypt / 0x08 decrypt).
//  - Raises per-slot result-valid flags that the bus side reads and clears.

---
 rtl/aes_block_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/aes_block_scheduler.sv
// rtl/aes_block_scheduler.sv - AES block/key sequencing controller (optional irq via AES_SCHED_IRQ_EN)
// Round-robin issue of buffered blocks to one AES core, key-expansion sequencing, per-slot result flags.
module aes_block_scheduler #(
  parameter int  NUM_SLOTS    = 4,
  parameter int  CORE_TIMEOUT = 64,
  localparam int SEL_W        = $clog2(NUM_SLOTS)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 key_loaded,
  input  logic                 mode_enc_wr,
  input  logic                 mode_dec_wr,
  input  logic [NUM_SLOTS-1:0] in_wr,
  input  logic [NUM_SLOTS-1:0] out_rd,
  input  logic                 keyexp_done,
  input  logic                 core_done,
  output logic                 keyexp_start,
  output logic                 core_start,
  output logic [SEL_W-1:0]     core_sel,
  output logic                 core_decrypt,
  output logic                 out_wr,
  output logic [NUM_SLOTS-1:0] out_valid,
  output logic                 key_ready,
  output logic                 busy,
  output logic                 err_timeout
`ifdef AES_SCHED_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int CNT_W = $clog2(CORE_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, KEY_START, KEY_WAIT, ISSUE, CORE_WAIT} state_t;

  state_t               state, state_n;
  logic [NUM_SLOTS-1:0] pend, pend_n, out_valid_n, elig, sel_mask;
  logic [SEL_W-1:0]     ptr, pick;
  logic [CNT_W-1:0]     tcnt;
  logic                 mode, key_req, tmo;
  logic                 do_issue, clr_pend, restore, key_done, tmo_set;

  assign elig     = pend & ~out_valid & {NUM_SLOTS{key_ready}};
  assign sel_mask = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << core_sel;
  assign tmo      = (tcnt == CNT_W'(CORE_TIMEOUT - 1));
  assign busy     = (state != IDLE);

  // Descending scan so the slot closest to ptr (lowest offset) wins.
  always_comb begin
    pick = ptr;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (elig[ptr + SEL_W'(k)]) pick = ptr + SEL_W'(k);
    end
  end

  always_comb begin
    state_n      = state;
    keyexp_start = 1'b0;
    core_start   = 1'b0;
    out_wr       = 1'b0;
    do_issue     = 1'b0;
    clr_pend     = 1'b0;
    restore      = 1'b0;
    key_done     = 1'b0;
    tmo_set      = 1'b0;
    case (state)
      IDLE: begin
        if (key_loaded) begin
          state_n = KEY_START;
        end else if (|elig) begin
          state_n  = ISSUE;
          do_issue = 1'b1;
        end
      end
      KEY_START: begin
        keyexp_start = 1'b1;
        state_n      = KEY_WAIT;
      end
      KEY_WAIT: begin
        if (key_loaded) begin
          state_n = KEY_START;
        end else if (keyexp_done) begin
          key_done = 1'b1;
          state_n  = IDLE;
        end else if (tmo) begin
          tmo_set = 1'b1;
          state_n = IDLE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        clr_pend   = 1'b1;
        state_n    = CORE_WAIT;
      end
      CORE_WAIT: begin
        if (core_done || tmo) begin
          tmo_set = !core_done;
          // A new key invalidates the in-flight result: drop it and re-run the block later.
          if (key_req || key_loaded) begin
            restore = 1'b1;
            state_n = KEY_START;
          end else begin
            out_wr  = core_done;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pend_n      = (pend & ~(clr_pend ? sel_mask : '0)) | in_wr | (restore ? sel_mask : '0);
  assign out_valid_n = (out_valid & ~out_rd) | (out_wr ? sel_mask : '0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend         <= '0;
      ptr          <= '0;
      mode         <= 1'b0;
      core_sel     <= '0;
      core_decrypt <= 1'b0;
      out_valid    <= '0;
      key_ready    <= 1'b0;
      err_timeout  <= 1'b0;
      key_req      <= 1'b0;
      tcnt         <= '0;
    end else begin
      pend      <= pend_n;
      out_valid <= out_valid_n;
      if (mode_dec_wr) mode <= 1'b1;
      else if (mode_enc_wr) mode <= 1'b0;
      if (do_issue) begin
        core_sel     <= pick;
        core_decrypt <= mode;
        ptr          <= pick + SEL_W'(1);
      end
      if (key_loaded || state == KEY_START) key_ready <= 1'b0;
      else if (key_done) key_ready <= 1'b1;
      if (tmo_set) err_timeout <= 1'b1;
      else if (key_loaded || state == KEY_START) err_timeout <= 1'b0;
      if (state_n == KEY_START) key_req <= 1'b0;
      else if (key_loaded && (state == ISSUE || state == CORE_WAIT)) key_req <= 1'b1;
      if (state != KEY_WAIT && state != CORE_WAIT) tcnt <= '0;
      else if (tcnt != CNT_W'(CORE_TIMEOUT)) tcnt <= tcnt + CNT_W'(1);
    end
  end

`ifdef AES_SCHED_IRQ_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq <= 1'b0;
    end else if (((&out_valid_n) && !(&out_valid)) || (tmo_set && !err_timeout)) begin
      irq <= 1'b1;
    end else if ((|out_rd) || key_loaded) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
